// File: rtl/wash_sequencer.sv
// Wash-stage phase sequencer: steps FILL/WASH/DRAIN/RINSE/SPIN on a prescaled 1 s tick,
// with pause/resume, abort and registered display/actuator outputs.
module wash_sequencer #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause_tgl,
  input  logic       abort,
  input  logic       ack,
  output logic       busy,
  output logic       done,
  output logic       buzzer,
  output logic [2:0] phase,
  output logic [7:0] remain,
  output logic [7:0] st_light,
  output logic [7:0] wt_light,
  output logic       valve_in,
  output logic       valve_out,
  output logic       motor
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    RINSE = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6
  } phase_t;

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [4:0]    FILL_LEN   = 5'd8;
  localparam logic [4:0]    DRAIN_LEN  = 5'd8;
  localparam logic [4:0]    RINSE_LEN  = 5'd5;
  localparam logic [1:0]    MODE_DRY   = 2'b00;

  function automatic logic [4:0] wash_len(input logic [1:0] m);
    case (m)
      2'b01:   return 5'd10;
      2'b10:   return 5'd20;
      2'b11:   return 5'd30;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [1:0] rinse_num(input logic [1:0] m);
    return m;  // quick 1, standard 2, heavy 3, dry 0
  endfunction

  function automatic logic [4:0] spin_len(input logic [1:0] m);
    case (m)
      2'b10:   return 5'd8;
      2'b11:   return 5'd10;
      default: return 5'd5;
    endcase
  endfunction

  function automatic logic [7:0] total_len(input logic [1:0] m);
    case (m)
      2'b01:   return 8'd52;
      2'b10:   return 8'd86;
      2'b11:   return 8'd119;
      default: return 8'd5;
    endcase
  endfunction

  phase_t        phase_q, phase_d;
  logic          paused_q, paused_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [1:0]    rinse_q, rinse_d;
  logic [1:0]    mode_q, mode_d;
  logic          washed_q, washed_d;
  logic [7:0]    remain_d, wt_d;
  logic          tick;
  logic          busy_d, done_d, vin_d, vout_d, motor_d;
  logic [7:0]    st_d;

  // State register; every output is a flop, so abort/reset values appear cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q   <= IDLE;
      paused_q  <= 1'b0;
      presc_q   <= '0;
      cnt_q     <= '0;
      rinse_q   <= '0;
      mode_q    <= '0;
      washed_q  <= 1'b0;
      remain    <= '0;
      wt_light  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      st_light  <= '0;
      valve_in  <= 1'b0;
      valve_out <= 1'b0;
      motor     <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every flop samples pre-edge values regardless of statement order.
      phase_q   <= phase_d;
      paused_q  <= paused_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      rinse_q   <= rinse_d;
      mode_q    <= mode_d;
      washed_q  <= washed_d;
      remain    <= remain_d;
      wt_light  <= wt_d;
      busy      <= busy_d;
      done      <= done_d;
      st_light  <= st_d;
      valve_in  <= vin_d;
      valve_out <= vout_d;
      motor     <= motor_d;
    end
  end

  assign phase  = phase_q;
  assign buzzer = done;

  // Next-state logic; priority is abort > ack > start > pause_tgl > tick.
  always_comb begin
    // NOTE: hold-value defaults up front keep this block free of inferred latches.
    phase_d  = phase_q;
    paused_d = paused_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    rinse_d  = rinse_q;
    mode_d   = mode_q;
    washed_d = washed_q;
    remain_d = remain;
    wt_d     = wt_light;
    tick     = 1'b0;

    if (abort) begin
      phase_d  = IDLE;
      paused_d = 1'b0;
      presc_d  = '0;
      cnt_d    = '0;
      rinse_d  = '0;
      washed_d = 1'b0;
      remain_d = '0;
      wt_d     = '0;
    end else begin
      case (phase_q)
        IDLE: begin
          if (start) begin
            mode_d   = mode;
            presc_d  = '0;
            paused_d = 1'b0;
            washed_d = 1'b0;
            rinse_d  = rinse_num(mode);
            remain_d = total_len(mode);
            wt_d     = '0;
            if (mode == MODE_DRY) begin
              phase_d = SPIN;
              cnt_d   = spin_len(mode);
            end else begin
              phase_d = FILL;
              cnt_d   = FILL_LEN;
            end
          end
        end
        DONE: begin
          if (ack) phase_d = IDLE;
        end
        FILL, WASH, DRAIN, RINSE, SPIN: begin
          // A pausing edge holds the prescaler; a resuming edge already counts,
          // so the held span equals the cycles spent paused.
          paused_d = paused_q ^ pause_tgl;
          if (!paused_d) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              tick    = 1'b1;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        default: begin
          phase_d  = IDLE;
          paused_d = 1'b0;
        end
      endcase

      if (tick) begin
        remain_d = (remain == 8'd0) ? 8'd0 : remain - 8'd1;
        case (phase_q)
          FILL:        wt_d = {wt_light[6:0], 1'b1};
          DRAIN:       wt_d = {1'b0, wt_light[7:1]};
          WASH, RINSE: wt_d = 8'hFF;
          default:     wt_d = 8'h00;
        endcase
        if (cnt_q > 5'd1) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          case (phase_q)
            FILL: begin
              if (washed_q) begin
                phase_d = RINSE;
                cnt_d   = RINSE_LEN;
              end else begin
                phase_d  = WASH;
                cnt_d    = wash_len(mode_q);
                washed_d = 1'b1;
              end
            end
            WASH: begin
              phase_d = DRAIN;
              cnt_d   = DRAIN_LEN;
            end
            RINSE: begin
              phase_d = DRAIN;
              cnt_d   = DRAIN_LEN;
              rinse_d = rinse_q - 2'd1;
            end
            DRAIN: begin
              if (rinse_q != 2'd0) begin
                phase_d = FILL;
                cnt_d   = FILL_LEN;
              end else begin
                phase_d = SPIN;
                cnt_d   = spin_len(mode_q);
              end
            end
            SPIN: begin
              phase_d = DONE;
              cnt_d   = '0;
            end
            default: phase_d = IDLE;
          endcase
        end
      end
    end
  end

  // Output decode from the next state, registered alongside it.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    st_d    = '0;
    vin_d   = 1'b0;
    vout_d  = 1'b0;
    motor_d = 1'b0;
    case (phase_d)
      FILL:  begin busy_d = 1'b1; st_d[0] = 1'b1; vin_d = 1'b1; end
      WASH:  begin busy_d = 1'b1; st_d[1] = 1'b1; motor_d = 1'b1; end
      DRAIN: begin busy_d = 1'b1; st_d[2] = 1'b1; vout_d = 1'b1; end
      RINSE: begin busy_d = 1'b1; st_d[3] = 1'b1; motor_d = 1'b1; end
      SPIN:  begin busy_d = 1'b1; st_d[4] = 1'b1; vout_d = 1'b1; motor_d = 1'b1; end
      DONE:  begin done_d = 1'b1; st_d[5] = 1'b1; end
      default: ;
    endcase
    st_d[6] = busy_d;
    st_d[7] = paused_d;
    if (paused_d) begin
      vin_d   = 1'b0;
      vout_d  = 1'b0;
      motor_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: stimulus queues edge-stamped expectations and the
// phase sequence; a monitor compares them one time unit after each rising edge.
module tb_wash_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, pause_tgl = 1'b0, abort = 1'b0, ack = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       busy, done, buzzer, valve_in, valve_out, motor;
  logic [2:0] phase;
  logic [7:0] remain, st_light, wt_light;

  wash_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pause_tgl(pause_tgl),
    .abort(abort), .ack(ack), .busy(busy), .done(done), .buzzer(buzzer),
    .phase(phase), .remain(remain), .st_light(st_light), .wt_light(wt_light),
    .valve_in(valve_in), .valve_out(valve_out), .motor(motor)
  );

  always #5 clk = ~clk;

  typedef enum int {F_PHASE, F_REMAIN, F_BUSY, F_DONE, F_BUZZ, F_ST, F_WT,
                    F_VIN, F_VOUT, F_MOTOR} f_t;
  typedef struct {
    int         at;
    f_t         f;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] ph_q[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic [2:0] prev_phase = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] field_val(input f_t f);
    case (f)
      F_PHASE:  return {5'd0, phase};
      F_REMAIN: return remain;
      F_BUSY:   return {7'd0, busy};
      F_DONE:   return {7'd0, done};
      F_BUZZ:   return {7'd0, buzzer};
      F_ST:     return st_light;
      F_WT:     return wt_light;
      F_VIN:    return {7'd0, valve_in};
      F_VOUT:   return {7'd0, valve_out};
      default:  return {7'd0, motor};
    endcase
  endfunction

  task automatic exp_at(input int at, input f_t f, input logic [7:0] v, input string name);
    exp_t e;
    e.at = at; e.f = f; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_idle(input int at, input string tag);
    exp_at(at, F_PHASE,  8'd0, {tag, "_phase"});
    exp_at(at, F_REMAIN, 8'd0, {tag, "_remain"});
    exp_at(at, F_BUSY,   8'd0, {tag, "_busy"});
    exp_at(at, F_DONE,   8'd0, {tag, "_done"});
    exp_at(at, F_BUZZ,   8'd0, {tag, "_buzzer"});
    exp_at(at, F_ST,     8'h00, {tag, "_st"});
    exp_at(at, F_WT,     8'h00, {tag, "_wt"});
    exp_at(at, F_VIN,    8'd0, {tag, "_vin"});
    exp_at(at, F_VOUT,   8'd0, {tag, "_vout"});
    exp_at(at, F_MOTOR,  8'd0, {tag, "_motor"});
  endtask

  task automatic push_phases(input logic [2:0] seq[$]);
    foreach (seq[i]) ph_q.push_back(seq[i]);
  endtask

  // Called at a falling edge; the pulse is sampled on the next rising edge (cyc + 1).
  task automatic pulse(input logic s, input logic p, input logic a, input logic k);
    start = s; pause_tgl = p; abort = a; ack = k;
    @(negedge clk);
    start = 1'b0; pause_tgl = 1'b0; abort = 1'b0; ack = 1'b0;
  endtask

  task automatic goto_edge(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask

  // Monitor: edge-stamped scoreboard plus an in-order phase-change checker.
  always @(posedge clk) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: expectation for edge %0d never sampled (now %0d)", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end else if (sb[i].at == cyc) begin
        check(sb[i].name, field_val(sb[i].f), sb[i].val);
        sb.delete(i);
      end
    end
    if (phase !== prev_phase) begin
      if (ph_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL phase_seq: unexpected change %0d -> %0d, expected none (edge %0d)", prev_phase, phase, cyc);
      end else begin
        check("phase_seq", {5'd0, phase}, {5'd0, ph_q.pop_front()});
      end
      prev_phase = phase;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, p, r, e, a;

    // Reset state while rst is held low.
    #12;
    check("rst_phase", {5'd0, phase}, 8'd0);
    check("rst_remain", remain, 8'd0);
    check("rst_st", st_light, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Quick run; mode changes mid-run to prove it was sampled at start.
    k = cyc + 1;
    push_phases('{3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd5, 3'd6, 3'd0});
    exp_at(k, F_PHASE, 8'd1, "q_phase");
    exp_at(k, F_REMAIN, 8'd52, "q_remain");
    exp_at(k, F_BUSY, 8'd1, "q_busy");
    exp_at(k, F_ST, 8'h41, "q_st_fill");
    exp_at(k, F_VIN, 8'd1, "q_vin");
    exp_at(k, F_MOTOR, 8'd0, "q_motor_fill");
    exp_at(k + 3, F_REMAIN, 8'd52, "q_remain_pretick");
    exp_at(k + 4, F_REMAIN, 8'd51, "q_remain_tick1");
    exp_at(k + 12, F_WT, 8'h07, "q_wt3");
    exp_at(k + 28, F_WT, 8'h7F, "q_wt7");
    exp_at(k + 32, F_WT, 8'hFF, "q_wt8");
    exp_at(k + 32, F_PHASE, 8'd2, "q_wash");
    exp_at(k + 32, F_MOTOR, 8'd1, "q_motor_wash");
    exp_at(k + 32, F_REMAIN, 8'd44, "q_remain_wash");
    exp_at(k + 72, F_VOUT, 8'd1, "q_vout_drain");
    exp_at(k + 76, F_WT, 8'h7F, "q_wt_drain1");
    exp_at(k + 136, F_ST, 8'h48, "q_st_rinse");
    exp_at(k + 207, F_DONE, 8'd0, "q_done_early");
    exp_at(k + 207, F_REMAIN, 8'd1, "q_remain_last");
    exp_at(k + 208, F_DONE, 8'd1, "q_done");
    exp_at(k + 208, F_BUZZ, 8'd1, "q_buzzer");
    exp_at(k + 208, F_PHASE, 8'd6, "q_phase_done");
    exp_at(k + 208, F_REMAIN, 8'd0, "q_remain_done");
    exp_at(k + 208, F_BUSY, 8'd0, "q_busy_done");
    exp_at(k + 208, F_ST, 8'h20, "q_st_done");
    exp_at(k + 208, F_MOTOR, 8'd0, "q_motor_done");
    mode = 2'b01;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    mode = 2'b11;
    goto_edge(k + 209);
    e = cyc + 1;
    exp_at(e, F_PHASE, 8'd0, "q_ack_phase");
    exp_at(e, F_DONE, 8'd0, "q_ack_done");
    exp_at(e, F_ST, 8'h00, "q_ack_st");
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Dry mode, pause_tgl ignored in DONE, then ack.
    k = cyc + 1;
    push_phases('{3'd5, 3'd6, 3'd0});
    exp_at(k, F_PHASE, 8'd5, "d_phase");
    exp_at(k, F_REMAIN, 8'd5, "d_remain");
    exp_at(k, F_MOTOR, 8'd1, "d_motor");
    exp_at(k, F_VOUT, 8'd1, "d_vout");
    exp_at(k, F_VIN, 8'd0, "d_vin");
    exp_at(k, F_ST, 8'h50, "d_st");
    exp_at(k + 19, F_PHASE, 8'd5, "d_spin_last");
    exp_at(k + 19, F_REMAIN, 8'd1, "d_remain_last");
    exp_at(k + 20, F_PHASE, 8'd6, "d_done_phase");
    exp_at(k + 20, F_DONE, 8'd1, "d_done");
    mode = 2'b00;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    goto_edge(k + 22);
    e = cyc + 1;
    exp_at(e, F_PHASE, 8'd6, "d_pause_in_done_phase");
    exp_at(e, F_ST, 8'h20, "d_pause_in_done_st");
    exp_at(e, F_DONE, 8'd1, "d_pause_in_done_done");
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    e = cyc + 1;
    exp_at(e, F_PHASE, 8'd0, "d_ack_phase");
    exp_at(e, F_ST, 8'h00, "d_ack_st");
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Heavy run with a 50-cycle pause inside WASH.
    k = cyc + 1;
    p = k + 46;
    r = p + 50;
    push_phases('{3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3,
                  3'd1, 3'd4, 3'd3, 3'd5, 3'd6, 3'd0});
    exp_at(k, F_REMAIN, 8'd119, "h_remain");
    exp_at(k + 44, F_PHASE, 8'd2, "h_wash");
    exp_at(k + 44, F_REMAIN, 8'd108, "h_remain_t11");
    exp_at(p, F_MOTOR, 8'd0, "h_motor_paused");
    exp_at(p, F_ST, 8'hC2, "h_st_paused");
    exp_at(p, F_BUSY, 8'd1, "h_busy_paused");
    exp_at(p + 25, F_REMAIN, 8'd108, "h_remain_frozen");
    exp_at(r - 1, F_REMAIN, 8'd108, "h_remain_frozen_end");
    exp_at(r - 1, F_WT, 8'hFF, "h_wt_frozen");
    exp_at(r, F_ST, 8'h42, "h_st_resumed");
    exp_at(r, F_MOTOR, 8'd1, "h_motor_resumed");
    exp_at(k + 97, F_REMAIN, 8'd108, "h_remain_pre_resume_tick");
    exp_at(k + 98, F_REMAIN, 8'd107, "h_remain_resume_tick");
    exp_at(k + 525, F_DONE, 8'd0, "h_done_early");
    exp_at(k + 526, F_DONE, 8'd1, "h_done");
    mode = 2'b11;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    goto_edge(p);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    goto_edge(r);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    goto_edge(k + 527);
    exp_at(cyc + 1, F_PHASE, 8'd0, "h_ack_phase");
    pulse(1'b0, 1'b0, 1'b0, 1'b1);

    // Standard run aborted during RINSE.
    k = cyc + 1;
    a = k + 180;
    push_phases('{3'd1, 3'd2, 3'd3, 3'd1, 3'd4, 3'd0});
    exp_at(k, F_REMAIN, 8'd86, "s_remain");
    exp_at(k + 176, F_PHASE, 8'd4, "s_rinse");
    exp_at(k + 176, F_ST, 8'h48, "s_st_rinse");
    exp_at(k + 176, F_WT, 8'hFF, "s_wt_rinse");
    exp_at(k + 176, F_REMAIN, 8'd42, "s_remain_rinse");
    exp_idle(a, "s_abort");
    mode = 2'b10;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    goto_edge(a);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // Restart reloads remain; start during WASH ignored; pause then abort.
    k = cyc + 1;
    push_phases('{3'd1, 3'd2, 3'd0});
    exp_at(k, F_REMAIN, 8'd86, "s2_remain");
    exp_at(k, F_PHASE, 8'd1, "s2_phase");
    exp_at(k + 34, F_PHASE, 8'd2, "s2_start_in_wash_phase");
    exp_at(k + 34, F_REMAIN, 8'd78, "s2_start_in_wash_remain");
    exp_at(k + 36, F_REMAIN, 8'd77, "s2_remain_after");
    exp_at(k + 37, F_ST, 8'hC2, "s2_paused_st");
    exp_idle(k + 40, "s2_abort_paused");
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    goto_edge(k + 34);
    mode = 2'b00;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    goto_edge(k + 37);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    goto_edge(k + 40);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // start + abort together in IDLE.
    e = cyc + 1;
    exp_idle(e, "sa_same");
    exp_at(e + 3, F_PHASE, 8'd0, "sa_later_phase");
    mode = 2'b01;
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    // Fresh start after a paused abort must not come up paused.
    k = cyc + 1;
    push_phases('{3'd1, 3'd0});
    exp_at(k, F_ST, 8'h41, "pc_st");
    exp_at(k, F_REMAIN, 8'd52, "pc_remain");
    exp_idle(k + 5, "pc_abort");
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    goto_edge(k + 5);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-FILL.
    k = cyc + 1;
    push_phases('{3'd1, 3'd0});
    exp_at(k, F_PHASE, 8'd1, "r_phase");
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    goto_edge(k + 14);
    check("r_wt_before", wt_light, 8'h07);
    #2 rst = 1'b0;
    #1;
    check("r_async_phase", {5'd0, phase}, 8'd0);
    check("r_async_remain", remain, 8'd0);
    check("r_async_wt", wt_light, 8'h00);
    check("r_async_st", st_light, 8'h00);
    check("r_async_busy", {7'd0, busy}, 8'd0);
    check("r_async_vin", {7'd0, valve_in}, 8'd0);
    check("r_async_act", {6'd0, valve_out, motor}, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    k = cyc + 1;
    push_phases('{3'd1, 3'd2, 3'd0});
    exp_at(k, F_PHASE, 8'd1, "r2_phase");
    exp_at(k, F_REMAIN, 8'd52, "r2_remain");
    exp_at(k + 32, F_PHASE, 8'd2, "r2_wash");
    exp_at(k + 32, F_WT, 8'hFF, "r2_wt");
    exp_idle(k + 34, "r2_abort");
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    goto_edge(k + 34);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 8'(sb.size()), 8'd0);
    check("phase_seq_drained", 8'(ph_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
# wash_sequencer

Phase sequencer for the washing-machine wash stage. Once started with a registered mode, it steps the machine through fill, wash, drain, rinse and spin phases on a 1 s tick. It drives the water-level and status lights, valve and motor enables, and a remaining-time counter, and supports pause/resume and abort. It sits between the top-level state controller (start, pause, abort, acknowledge pulses from debounced buttons) and the display and actuator outputs.

## Interface

- TICK_DIV, 100_000_000, clk cycles per 1 s tick (≥2)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- mode  in  2  00 dry/spin-only, 01 quick, 10 standard, 11 heavy; sampled on accepted start
- pause_tgl  in  1  one-cycle pulse; toggles pause while busy
- abort  in  1  one-cycle pulse; return to IDLE
- ack  in  1  one-cycle pulse; leaves DONE
- busy  out  1  high in FILL/WASH/DRAIN/RINSE/SPIN
- done  out  1  high while in DONE
- buzzer  out  1  high while in DONE
- phase  out  3  0 IDLE, 1 FILL, 2 WASH, 3 DRAIN, 4 RINSE, 5 SPIN, 6 DONE
- remain  out  8  seconds remaining, binary
- st_light  out  8  [0]FILL [1]WASH [2]DRAIN [3]RINSE [4]SPIN [5]DONE [6]busy [7]paused
- wt_light  out  8  water level, thermometer code
- valve_in, valve_out, motor  out  1 each  actuator enables

## Operation

**Per-mode constants** (wash s / rinse count / spin s):
- quick: 10 / 1 / 5
- standard: 20 / 2 / 8
- heavy: 30 / 3 / 10
- dry: 0 / 0 / 5, SPIN only

**Fixed phase lengths**
- FILL = 8 s; DRAIN = 8 s; RINSE agitation = 5 s.

**Total time** `remain` loaded on start = 8 + W + 8 + R·21 + S.
- quick 52, standard 86, heavy 119, dry 5.

**Sequence**
- IDLE → FILL (dry mode: → SPIN).
- FILL → WASH on first fill, → RINSE otherwise (internal `washed` flag).
- WASH → DRAIN.
- RINSE → DRAIN, decrementing the rinse counter.
- DRAIN → FILL if rinses remain, else → SPIN.
- SPIN → DONE.
- DONE → IDLE on ack.
- Phase code 7 → IDLE.

**Per-tick behaviour** (running, not paused)
- Phase counter decrements; at count 1 the transition happens on that tick and the next phase counter loads.
- `remain` decrements, saturating at 0.
- FILL: wt_light ← {wt_light[6:0],1}.
- DRAIN: wt_light ← {0,wt_light[7:1]}.
- WASH/RINSE: wt_light = FF.
- SPIN/IDLE/DONE: wt_light = 00.

**Actuators** (all forced 0 while paused)
- valve_in = FILL.
- valve_out = DRAIN or SPIN.
- motor = WASH, RINSE or SPIN.

**Pause**
- pause_tgl while busy toggles `paused`.
- While paused: prescaler, phase counter, remain and wt_light all hold.
- pause_tgl is ignored in IDLE and DONE.

**Abort**
- From any state: go to IDLE and clear every output to its reset value, including paused.

**Priority within one cycle**: abort > ack > start > pause_tgl > tick.
- start in a non-IDLE state is ignored.
- start and abort together in IDLE: remain IDLE.

## Timing

- All outputs are registered.
- Reset values: phase 0, remain 0, busy 0, done 0, buzzer 0, st_light 00, wt_light 00, valve_in/valve_out/motor 0; paused cleared, prescaler 0.
- Start accepted at edge k: at k+1 phase=1 (dry: 5), busy=1, remain=total, prescaler=0.
- Tick fires when the prescaler wraps TICK_DIV−1 → 0. The first tick occurs TICK_DIV cycles after phase entry, and state updates on that same edge.
- Prescaler runs only while busy and not paused, and resets on start and abort.
- On the final SPIN tick: phase=6, remain=0, done=1 and buzzer=1 on the same edge.
- ack at edge m: IDLE at m+1.
- Resume: the prescaler continues from its held value, so no partial tick is lost or duplicated.
- Asynchronous reset mid-phase: all outputs return to reset values immediately, without waiting for a clock edge.

## Test plan

Benches use TICK_DIV=4.

- **Quick run.** Reset, mode=01, start pulse → remain=52 next cycle; phase sequence 1,2,3,1,4,3,5,6. done rises exactly 208 cycles after start acceptance. wt_light reaches FF after 8 ticks.
- **Dry mode.** mode=00 start → phase=5, remain=5, motor=1, valve_out=1. DONE after 20 cycles; ack → phase 0 next cycle.
- **Pause.** Heavy run: pause_tgl at tick 3 of WASH → motor=0, st_light[7]=1, remain frozen for 50 cycles. Second pause_tgl resumes; total completion time extended by exactly the paused cycles (476 + pause).
- **Abort.** Standard run, abort during RINSE → next cycle phase=0, remain=0, wt_light=00, all actuators 0. A following start reloads remain=86.
- **Simultaneous events.** start+abort in IDLE → stays IDLE. pause_tgl in DONE → no effect. start during WASH → ignored, remain unaffected.
- **Reset mid-FILL.** Assert rst while wt_light=07 → all outputs zero asynchronously; after release, start works normally.
